char_rom_arbiter: RTL and testbench

CHAR_ROM_ARBITER -- requirements
Module: char_rom_arbiter

---
 rtl/char_rom_arbiter_pkg.sv | 16 +
 rtl/char_req_tag_pipe.sv | 35 +++
 rtl/char_rom_arbiter.sv | 102 ++++++++++
 tb/tb_char_rom_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_rom_arbiter_pkg.sv
// rtl/char_rom_arbiter_pkg.sv - shared draw types and widths for the char ROM arbiter
package char_rom_arbiter_pkg;

  localparam int XY_W   = 8;
  localparam int CODE_W = 7;

  typedef enum logic {
    REQ_MENU   = 1'b0,
    REQ_TOPBAR = 1'b1
  } req_id_t;

  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_MENU) ? REQ_TOPBAR : REQ_MENU;
  endfunction

endpackage

// File: rtl/char_req_tag_pipe.sv
// rtl/char_req_tag_pipe.sv - valid/tag shift pipe that follows each ROM lookup
module char_req_tag_pipe
  import char_rom_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  input  req_id_t in_tag,
  output logic    out_valid,
  output req_id_t out_tag
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] tag_q;

  // advance the lookup markers one stage per cycle; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= {valid_q[DEPTH-2:0], in_valid};
    end
  end

  // tags only matter where the matching valid bit is set, so they need no reset
  always_ff @(posedge clk) begin
    tag_q <= {tag_q[DEPTH-2:0], in_tag};
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_tag   = req_id_t'(tag_q[DEPTH-1]);

endmodule

// File: rtl/char_rom_arbiter.sv
// rtl/char_rom_arbiter.sv - two-requester round-robin arbiter with lock for a shared char ROM
module char_rom_arbiter
  import char_rom_arbiter_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [XY_W-1:0]   req0_xy,
  input  logic              req0_lock,
  input  logic              req1_valid,
  input  logic [XY_W-1:0]   req1_xy,
  input  logic              req1_lock,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic [XY_W-1:0]   rom_xy,
  input  logic [CODE_W-1:0] rom_code,
  output logic              rsp0_valid,
  output logic [CODE_W-1:0] rsp0_code,
  output logic              rsp1_valid,
  output logic [CODE_W-1:0] rsp1_code
);

  localparam int PIPE_DEPTH = 1 + ROM_LAT;

  req_id_t           prio_q;
  logic              lock_q;
  req_id_t           holder;
  logic              grant_valid;
  req_id_t           grant_id;
  logic              grant_lock;
  logic [XY_W-1:0]   grant_xy;
  logic              pipe_valid;
  req_id_t           pipe_tag;

  // the last winner is always the one the pointer is not favouring
  assign holder = other_req(prio_q);

  // pick this cycle's winner: a locked holder first, then the round-robin pointer
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = prio_q;
    if (lock_q && holder == REQ_MENU && req0_valid && req0_lock) begin
      grant_valid = 1'b1;
      grant_id    = REQ_MENU;
    end else if (lock_q && holder == REQ_TOPBAR && req1_valid && req1_lock) begin
      grant_valid = 1'b1;
      grant_id    = REQ_TOPBAR;
    end else if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = prio_q;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant_id    = REQ_MENU;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = REQ_TOPBAR;
    end
    if (!rst) begin
      grant_valid = 1'b0;
    end
  end

  assign grant_xy   = (grant_id == REQ_MENU) ? req0_xy : req1_xy;
  assign grant_lock = (grant_id == REQ_MENU) ? req0_lock : req1_lock;
  assign req0_ready = grant_valid && (grant_id == REQ_MENU);
  assign req1_ready = grant_valid && (grant_id == REQ_TOPBAR);

  // pointer, lock state and ROM address update on every accepted lookup
  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_q <= REQ_MENU;
      lock_q <= 1'b0;
      rom_xy <= '0;
    end else begin
      lock_q <= grant_valid && grant_lock;
      if (grant_valid) begin
        prio_q <= other_req(grant_id);
        rom_xy <= grant_xy;
      end
    end
  end

  char_req_tag_pipe #(
    .DEPTH(PIPE_DEPTH)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (grant_valid),
    .in_tag   (grant_id),
    .out_valid(pipe_valid),
    .out_tag  (pipe_tag)
  );

  // the lookup leaving the pipe lines up with rom_code; steer it to its owner
  assign rsp0_valid = rst && pipe_valid && (pipe_tag == REQ_MENU);
  assign rsp1_valid = rst && pipe_valid && (pipe_tag == REQ_TOPBAR);
  assign rsp0_code  = rsp0_valid ? rom_code : '0;
  assign rsp1_code  = rsp1_valid ? rom_code : '0;

endmodule

// File: tb/tb_char_rom_arbiter.sv
// tb/tb_char_rom_arbiter.sv - self-checking bench for char_rom_arbiter at ROM_LAT 1 and 3
module tb_char_rom_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req0_valid, req1_valid, req0_lock, req1_lock;
  logic [7:0] req0_xy, req1_xy;

  logic       d1_rdy0, d1_rdy1, d1_rv0, d1_rv1;
  logic [6:0] d1_rc0, d1_rc1, d1_rom_code;
  logic [7:0] d1_rom_xy;
  logic       d3_rdy0, d3_rdy1, d3_rv0, d3_rv1;
  logic [6:0] d3_rc0, d3_rc1, d3_rom_code;
  logic [7:0] d3_rom_xy;

  char_rom_arbiter #(.ROM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_xy(req0_xy), .req0_lock(req0_lock),
    .req1_valid(req1_valid), .req1_xy(req1_xy), .req1_lock(req1_lock),
    .req0_ready(d1_rdy0), .req1_ready(d1_rdy1),
    .rom_xy(d1_rom_xy), .rom_code(d1_rom_code),
    .rsp0_valid(d1_rv0), .rsp0_code(d1_rc0),
    .rsp1_valid(d1_rv1), .rsp1_code(d1_rc1)
  );

  char_rom_arbiter #(.ROM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_xy(req0_xy), .req0_lock(req0_lock),
    .req1_valid(req1_valid), .req1_xy(req1_xy), .req1_lock(req1_lock),
    .req0_ready(d3_rdy0), .req1_ready(d3_rdy1),
    .rom_xy(d3_rom_xy), .rom_code(d3_rom_code),
    .rsp0_valid(d3_rv0), .rsp0_code(d3_rc0),
    .rsp1_valid(d3_rv1), .rsp1_code(d3_rc1)
  );

  logic [7:0] name_row [9] = '{8'h42, 8'h54, 8'h4E, 8'h4C, 8'h2D, 8'h45, 8'h41, 8'h53, 8'h59};

  function automatic logic [6:0] rom_func(input logic [7:0] xy);
    logic [7:0] b;
    if (xy == 8'hF0) return 7'h00;
    if (xy == 8'h10) return 7'h41;
    if (xy[3:0] == 4'h6 && xy[7:4] >= 4'd1 && xy[7:4] <= 4'd9) begin
      b = name_row[int'(xy[7:4]) - 1];
      return b[6:0];
    end
    return xy[6:0] ^ 7'h2A;
  endfunction

  logic [6:0] rom1_q = 7'h00;
  logic [6:0] rom3_q [3] = '{7'h00, 7'h00, 7'h00};
  always @(posedge clk) begin
    rom1_q    <= rom_func(d1_rom_xy);
    rom3_q[0] <= rom_func(d3_rom_xy);
    rom3_q[1] <= rom3_q[0];
    rom3_q[2] <= rom3_q[1];
  end
  assign d1_rom_code = rom1_q;
  assign d3_rom_code = rom3_q[2];

  logic [3:0]  rdy;
  logic [15:0] act1, act3;
  assign rdy  = {d1_rdy0, d1_rdy1, d3_rdy0, d3_rdy1};
  assign act1 = {d1_rv0, d1_rc0, d1_rv1, d1_rc1};
  assign act3 = {d3_rv0, d3_rc0, d3_rv1, d3_rc1};

  typedef struct {
    int         due;
    int         id;
    logic [6:0] code;
  } rsp_t;

  rsp_t        q1[$];
  rsp_t        q3[$];
  int          m_last = -1;
  bit          m_locked = 1'b0;
  logic [7:0]  m_xy = 8'h00;
  int          t = 0;
  int          e_grant;
  logic [3:0]  e_rdy;
  logic [15:0] e_rsp1, e_rsp3;
  int          checks = 0;
  int          errors = 0;

  function automatic int model_grant();
    if (!rst) return -1;
    if (m_locked && m_last == 0 && req0_valid && req0_lock) return 0;
    if (m_locked && m_last == 1 && req1_valid && req1_lock) return 1;
    if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic logic [15:0] exp_rsp(input rsp_t q[$]);
    logic [15:0] r = 16'h0000;
    if (rst && q.size() > 0 && q[0].due == t)
      r = (q[0].id == 0) ? {1'b1, q[0].code, 8'h00} : {8'h00, 1'b1, q[0].code};
    return r;
  endfunction

  task automatic drive(input logic r, input logic v0, input logic [7:0] x0, input logic l0,
                       input logic v1, input logic [7:0] x1, input logic l1);
    rst = r;
    req0_valid = v0; req0_xy = x0; req0_lock = l0;
    req1_valid = v1; req1_xy = x1; req1_lock = l1;
    @(negedge clk);
    e_grant = model_grant();
    e_rdy   = {e_grant == 0, e_grant == 1, e_grant == 0, e_grant == 1};
    e_rsp1  = exp_rsp(q1);
    e_rsp3  = exp_rsp(q3);
  endtask

  task automatic commit();
    logic [6:0] code;
    @(posedge clk);
    if (!rst) begin
      q1.delete(); q3.delete();
      m_last = -1; m_locked = 1'b0; m_xy = 8'h00;
    end else begin
      if (q1.size() > 0 && q1[0].due == t) void'(q1.pop_front());
      if (q3.size() > 0 && q3[0].due == t) void'(q3.pop_front());
      if (e_grant >= 0) begin
        m_xy = (e_grant == 0) ? req0_xy : req1_xy;
        code = rom_func(m_xy);
        q1.push_back('{t + 2, e_grant, code});
        q3.push_back('{t + 4, e_grant, code});
        m_locked = (e_grant == 0) ? req0_lock : req1_lock;
        m_last = e_grant;
      end else begin
        m_locked = 1'b0;
      end
    end
    t++;
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 8'($urandom), 1'b1, 1'b1, 8'($urandom), 1'b1);
      checks++; if (rdy !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", rdy); end
      checks++; if ({act1, act3} !== 32'h0) begin errors++; $display("FAIL reset_rsp got %h want 0", {act1, act3}); end
      checks++; if ({d1_rom_xy, d3_rom_xy} !== 16'h0000) begin errors++; $display("FAIL reset_rom_xy got %h want 0000", {d1_rom_xy, d3_rom_xy}); end
      commit();
    end
  endtask

  task automatic test_single();
    logic [7:0] xy;
    logic [6:0] want;
    for (int i = 0; i < 2; i++) begin
      xy   = (i == 0) ? 8'h10 : 8'hF0;
      want = (i == 0) ? 7'h41 : 7'h00;
      for (int k = 0; k < 6; k++) begin
        drive(1'b1, k == 0, xy, 1'b0, 1'b0, 8'($urandom), 1'b0);
        checks++; if (rdy !== e_rdy) begin errors++; $display("FAIL single_ready t=%0d got %b want %b", t, rdy, e_rdy); end
        checks++; if ({act1, act3} !== {e_rsp1, e_rsp3}) begin errors++; $display("FAIL single_rsp t=%0d got %h want %h", t, {act1, act3}, {e_rsp1, e_rsp3}); end
        checks++; if ({d1_rom_xy, d3_rom_xy} !== {m_xy, m_xy}) begin errors++; $display("FAIL single_rom_xy t=%0d got %h want %h", t, {d1_rom_xy, d3_rom_xy}, {m_xy, m_xy}); end
        if (k == 0) begin
          checks++; if ({d1_rdy0, d1_rdy1} !== 2'b10) begin errors++; $display("FAIL single_accept got %b want 10", {d1_rdy0, d1_rdy1}); end
        end
        if (k == 1) begin
          checks++; if (d1_rom_xy !== xy) begin errors++; $display("FAIL single_addr got %h want %h", d1_rom_xy, xy); end
        end
        checks++; if ({d1_rv0, d1_rc0, d1_rv1} !== ((k == 2) ? {1'b1, want, 1'b0} : 9'h000))
          begin errors++; $display("FAIL single_code k=%0d got %b/%h/%b want pulse at k=2 code %h", k, d1_rv0, d1_rc0, d1_rv1, want); end
        commit();
      end
    end
  endtask

  task automatic test_contention();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    commit();
    for (int k = 0; k < 14; k++) begin
      drive(1'b1, k < 8, 8'($urandom), 1'b0, k < 8, 8'($urandom), 1'b0);
      checks++; if (rdy !== e_rdy) begin errors++; $display("FAIL cont_ready t=%0d got %b want %b", t, rdy, e_rdy); end
      checks++; if ({act1, act3} !== {e_rsp1, e_rsp3}) begin errors++; $display("FAIL cont_rsp t=%0d got %h want %h", t, {act1, act3}, {e_rsp1, e_rsp3}); end
      checks++; if ({d1_rom_xy, d3_rom_xy} !== {m_xy, m_xy}) begin errors++; $display("FAIL cont_rom_xy t=%0d got %h want %h", t, {d1_rom_xy, d3_rom_xy}, {m_xy, m_xy}); end
      if (k < 8) begin
        checks++; if (rdy !== ((k % 2 == 0) ? 4'b1010 : 4'b0101)) begin errors++; $display("FAIL cont_alternate k=%0d got %b", k, rdy); end
      end
      commit();
    end
  endtask

  task automatic test_lock();
    int j = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 0)      drive(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0, 8'h00, 1'b0);
      else if (k < 10) drive(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b1, {4'(k), 4'h6}, 1'b1);
      else if (k == 10) drive(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b1, 8'($urandom), 1'b0);
      else             drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      checks++; if (rdy !== e_rdy) begin errors++; $display("FAIL lock_ready t=%0d got %b want %b", t, rdy, e_rdy); end
      checks++; if ({act1, act3} !== {e_rsp1, e_rsp3}) begin errors++; $display("FAIL lock_rsp t=%0d got %h want %h", t, {act1, act3}, {e_rsp1, e_rsp3}); end
      checks++; if ({d1_rom_xy, d3_rom_xy} !== {m_xy, m_xy}) begin errors++; $display("FAIL lock_rom_xy t=%0d got %h want %h", t, {d1_rom_xy, d3_rom_xy}, {m_xy, m_xy}); end
      if (k >= 1 && k < 10) begin
        checks++; if (rdy !== 4'b0101) begin errors++; $display("FAIL lock_hold k=%0d got %b want 0101", k, rdy); end
      end
      if (k == 10) begin
        checks++; if (rdy !== 4'b1010) begin errors++; $display("FAIL lock_release got %b want 1010", rdy); end
      end
      if (d1_rv1 === 1'b1) begin
        checks++; if (j >= 9 || d1_rc1 !== name_row[j < 9 ? j : 0][6:0])
          begin errors++; $display("FAIL lock_code idx=%0d got %h", j, d1_rc1); end
        j++;
      end
      commit();
    end
    checks++; if (j !== 9) begin errors++; $display("FAIL lock_count got %0d want 9", j); end
  endtask

  task automatic test_reset_midflight();
    for (int k = 0; k < 9; k++) begin
      if (k == 0)      drive(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0, 8'h00, 1'b0);
      else if (k == 1) drive(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b1, 8'($urandom), 1'b0);
      else if (k == 2) drive(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b1, 8'($urandom), 1'b0);
      else             drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      checks++; if (rdy !== e_rdy) begin errors++; $display("FAIL mid_ready t=%0d got %b want %b", t, rdy, e_rdy); end
      checks++; if ({act1, act3} !== {e_rsp1, e_rsp3}) begin errors++; $display("FAIL mid_rsp t=%0d got %h want %h", t, {act1, act3}, {e_rsp1, e_rsp3}); end
      checks++; if ({d1_rom_xy, d3_rom_xy} !== {m_xy, m_xy}) begin errors++; $display("FAIL mid_rom_xy t=%0d got %h want %h", t, {d1_rom_xy, d3_rom_xy}, {m_xy, m_xy}); end
      if (k == 2) begin
        checks++; if ({rdy, d1_rom_xy, d1_rv0} !== {4'b1010, 8'h00, 1'b0})
          begin errors++; $display("FAIL mid_after_reset got rdy=%b xy=%h rv0=%b want 1010/00/0", rdy, d1_rom_xy, d1_rv0); end
      end
      if (k == 4) begin
        checks++; if ({d3_rv0, d3_rv1} !== 2'b00) begin errors++; $display("FAIL mid_lat3_drop got %b want 00", {d3_rv0, d3_rv1}); end
      end
      commit();
    end
  endtask

  task automatic test_back_to_back();
    logic v0, v1;
    for (int k = 0; k < 410; k++) begin
      v0 = (k < 400) && ($urandom_range(0, 3) != 0);
      v1 = (k < 400) && ($urandom_range(0, 3) != 0);
      drive(1'b1, v0, 8'($urandom), $urandom_range(0, 3) == 0, v1, 8'($urandom), $urandom_range(0, 3) == 0);
      checks++; if (rdy !== e_rdy) begin errors++; $display("FAIL b2b_ready t=%0d got %b want %b", t, rdy, e_rdy); end
      checks++; if ({act1, act3} !== {e_rsp1, e_rsp3}) begin errors++; $display("FAIL b2b_rsp t=%0d got %h want %h", t, {act1, act3}, {e_rsp1, e_rsp3}); end
      checks++; if ({d1_rom_xy, d3_rom_xy} !== {m_xy, m_xy}) begin errors++; $display("FAIL b2b_rom_xy t=%0d got %h want %h", t, {d1_rom_xy, d3_rom_xy}, {m_xy, m_xy}); end
      commit();
    end
    checks++; if (q1.size() + q3.size() !== 0) begin errors++; $display("FAIL b2b_drain got %0d pending want 0", q1.size() + q3.size()); end
  endtask

  initial begin
    rst = 1'b0;
    req0_valid = 1'b0; req0_xy = 8'h00; req0_lock = 1'b0;
    req1_valid = 1'b0; req1_xy = 8'h00; req1_lock = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_reset_midflight();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
